// File: rtl/sw_out_sched_if.sv
// Switch-scheduler bundle: receive-unit request/grant, shared buffer read bus and the
// downstream two-phase flit channel. The scheduler uses master, the environment slave.
interface sw_out_sched_if #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned SIZE         = 8,
    parameter int unsigned CHANNEL_BITS = 3,
    parameter int unsigned BUFF_BITS    = 3
);
    logic [PORTS-1:0]              in_req;
    logic [PORTS*CHANNEL_BITS-1:0] in_chnl;
    logic [PORTS-1:0]              in_gnt;
    logic [BUFF_BITS-1:0]          buf_addr;
    logic [PORTS*SIZE-1:0]         buf_data;
    logic                          ch_req;
    logic [SIZE-1:0]               ch_flit;
    logic                          ch_ack;

    modport master (
        input  in_req, in_chnl, buf_data, ch_ack,
        output in_gnt, buf_addr, ch_req, ch_flit
    );

    modport slave (
        output in_req, in_chnl, buf_data, ch_ack,
        input  in_gnt, buf_addr, ch_req, ch_flit
    );
endinterface

// File: rtl/sw_out_sched.sv
// Per-output-channel switch scheduler: round-robin grant to one receive unit, then streams
// its FLIT_COUNT flits to the downstream link over a toggle req/ack channel.
module sw_out_sched #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned OUT_CHANNEL  = 0,
    parameter int unsigned SIZE         = 8,
    parameter int unsigned CHANNEL_BITS = 3,
    parameter int unsigned BUFF_BITS    = 3
) (
    input logic             clk,
    input logic             reset,
    sw_out_sched_if.master  bus
);
    localparam int unsigned PtrW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [BUFF_BITS-1:0] LastAddr = {BUFF_BITS{1'b1}};

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFetch   = 2'd1;
    localparam logic [1:0] StWaitAck = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [PtrW-1:0]      winner_q, winner_d;
    logic [PORTS-1:0]     gnt_q, gnt_d;
    logic [BUFF_BITS-1:0] addr_q, addr_d;
    logic                 req_q, req_d;
    logic [SIZE-1:0]      flit_q, flit_d;
    logic                 ack_old_q;

    logic [PORTS-1:0]     eligible;
    logic [PORTS-1:0]     gnt_pick;
    logic [PtrW-1:0]      pick;
    logic [PtrW-1:0]      idx;
    logic                 found;
    logic [SIZE-1:0]      sel_flit;
    logic                 ack_event;

    assign ack_event = bus.ch_ack ^ ack_old_q;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            eligible[i] = bus.in_req[i] &&
                (bus.in_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(OUT_CHANNEL));
        end
    end

    // Search starts just after the last winner, so it has lowest priority next time.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            idx = PtrW'((32'(ptr_q) + k) % PORTS);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        gnt_pick = '0;
        sel_flit = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            gnt_pick[i] = (pick == PtrW'(i));
            if (winner_q == PtrW'(i)) begin
                sel_flit = bus.buf_data[i*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        req_d    = req_q;
        flit_d   = flit_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    winner_d = pick;
                    gnt_d    = gnt_pick;
                    addr_d   = '0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                flit_d  = sel_flit;
                req_d   = ~req_q;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (ack_event) begin
                    if (addr_q == LastAddr) begin
                        gnt_d   = '0;
                        ptr_d   = winner_q;
                        state_d = StRelease;
                    end else begin
                        addr_d  = addr_q + BUFF_BITS'(1);
                        state_d = StFetch;
                    end
                end
            end
            // Grant-low gap lets the served unit drop back to idle before re-arbitration.
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= PtrW'(PORTS - 1);
            winner_q  <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            flit_q    <= '0;
            ack_old_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            winner_q  <= winner_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            flit_q    <= flit_d;
            ack_old_q <= bus.ch_ack;
        end
    end

    assign bus.in_gnt   = gnt_q;
    assign bus.buf_addr = addr_q;
    assign bus.ch_req   = req_q;
    assign bus.ch_flit  = flit_q;
endmodule

// File: tb/tb_sw_out_sched.sv
// Scoreboard bench for sw_out_sched: stimulus pushes expected grants/flits, a negedge
// monitor pops and compares them as the scheduler presents grants and ch_req toggles.
module tb_sw_out_sched;
    localparam int unsigned PORTS = 4;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned CB    = 3;
    localparam int unsigned BB    = 3;
    localparam int unsigned FC    = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sw_out_sched_if #(.PORTS(PORTS), .SIZE(SIZE), .CHANNEL_BITS(CB), .BUFF_BITS(BB)) bus ();

    sw_out_sched #(
        .PORTS(PORTS), .OUT_CHANNEL(0), .SIZE(SIZE), .CHANNEL_BITS(CB), .BUFF_BITS(BB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [7:0] mem [PORTS][FC];
    for (genvar g = 0; g < PORTS; g++) begin : g_buf
        assign bus.buf_data[g*SIZE +: SIZE] = mem[g][bus.buf_addr];
    end

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_flit [$];
    int         exp_gnt  [$];

    // Downstream / receive-unit model state
    logic req_seen;
    int   ack_cnt;
    int   fidx;
    int   slow_idx = -1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            if (bus.ch_req != req_seen) begin
                req_seen = bus.ch_req;
                ack_cnt  = (fidx == slow_idx) ? 20 : 3;
                fidx++;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) bus.ch_ack = ~bus.ch_ack;
            end
            for (int i = 0; i < PORTS; i++) begin
                if (bus.in_gnt[i]) bus.in_req[i] = 1'b0;
            end
            if (bus.in_gnt == '0) fidx = 0;
        end
    endtask

    task automatic push_pkt(input int p);
        exp_gnt.push_back(p);
        for (int a = 0; a < FC; a++) exp_flit.push_back(mem[p][a]);
    endtask

    task automatic request(input int p, input logic [2:0] ch);
        bus.in_chnl[p*CB +: CB] = ch;
        bus.in_req[p]           = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!(exp_flit.size() == 0 && exp_gnt.size() == 0 && bus.in_gnt == '0 &&
                 ack_cnt == 0) && n < budget) begin
            tick();
            n++;
        end
        chk(n < budget, name, n, budget);
        repeat (3) tick();
    endtask

    task automatic wait_fidx(input int target, input bit ack_idle, input string name);
        int n = 0;
        while (!(fidx == target && (!ack_idle || ack_cnt == 0)) && n < 300) begin
            tick();
            n++;
        end
        chk(n < 300, name, n, 300);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        chk(bus.in_gnt == '0,   {tag, "_gnt"},  32'(bus.in_gnt),   0);
        chk(bus.buf_addr == '0, {tag, "_addr"}, 32'(bus.buf_addr), 0);
        chk(bus.ch_req == 1'b0, {tag, "_req"},  32'(bus.ch_req),   0);
        chk(bus.ch_flit == '0,  {tag, "_flit"}, 32'(bus.ch_flit),  0);
        exp_flit.delete();
        exp_gnt.delete();
        bus.in_req = '0;
        bus.ch_ack = 1'b0;
        req_seen   = 1'b0;
        ack_cnt    = 0;
        fidx       = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    // Monitor / scoreboard
    logic       m_prev_req, m_prev_ack;
    logic [3:0] m_prev_gnt;
    int         m_cnt, m_since_gnt, m_ack_age, m_port;
    bit         m_drop_due;
    logic [7:0] m_flit;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cnt = 0; m_since_gnt = 0; m_ack_age = 0; m_drop_due = 0;
            end else begin
                m_since_gnt++;
                m_ack_age++;
                if (m_drop_due) begin
                    chk(bus.in_gnt == '0, "gnt_drop_timing", 32'(bus.in_gnt), 0);
                    m_drop_due = 0;
                end
                if (bus.in_gnt != m_prev_gnt) begin
                    if (m_prev_gnt != '0) begin
                        chk(bus.in_gnt == '0, "gnt_stable", 32'(bus.in_gnt), 32'(m_prev_gnt));
                        chk(m_cnt == FC, "pkt_len", m_cnt, FC);
                    end else if (exp_gnt.size() == 0) begin
                        chk(1'b0, "unexpected_gnt", 32'(bus.in_gnt), 0);
                    end else begin
                        m_port = exp_gnt.pop_front();
                        chk(bus.in_gnt == 4'(1 << m_port), "gnt_winner", 32'(bus.in_gnt),
                            32'(1 << m_port));
                        chk(bus.buf_addr == '0, "addr_start", 32'(bus.buf_addr), 0);
                        m_cnt       = 0;
                        m_since_gnt = 0;
                    end
                end
                if (bus.ch_req != m_prev_req) begin
                    if (exp_flit.size() == 0) begin
                        chk(1'b0, "unexpected_flit", 32'(bus.ch_flit), 0);
                    end else begin
                        m_flit = exp_flit.pop_front();
                        chk(bus.ch_flit == m_flit, "flit", 32'(bus.ch_flit), 32'(m_flit));
                        chk(32'(bus.buf_addr) == m_cnt, "flit_addr", 32'(bus.buf_addr), m_cnt);
                        if (m_cnt == 0) chk(m_since_gnt == 1, "first_req_lat", m_since_gnt, 1);
                        else chk(m_ack_age == 2, "ack_to_req_lat", m_ack_age, 2);
                        m_cnt++;
                    end
                end
                if (bus.ch_ack != m_prev_ack) begin
                    m_ack_age = 0;
                    if (m_cnt == FC) m_drop_due = 1;
                end
            end
            m_prev_req = bus.ch_req;
            m_prev_ack = bus.ch_ack;
            m_prev_gnt = bus.in_gnt;
        end
    end

    initial begin
        logic       r0;
        logic [7:0] f0;
        bit         bad;
        for (int p = 0; p < PORTS; p++) begin
            for (int a = 0; a < FC; a++) begin
                mem[p][a] = (p == 2) ? ((a == 0) ? 8'h80 : 8'(a)) : 8'(160 + 16 * p + a);
            end
        end
        bus.in_req  = '0;
        bus.in_chnl = '0;
        bus.ch_ack  = 1'b0;
        req_seen    = 1'b0;
        ack_cnt     = 0;
        fidx        = 0;
        #2;
        apply_reset("rst0");

        // Single requester on port 2
        push_pkt(2);
        request(2, 3'd0);
        wait_done(300, "single_done");

        // Request for another channel is ignored
        r0  = bus.ch_req;
        bad = 0;
        request(1, 3'd3);
        repeat (50) begin
            tick();
            if (bus.in_gnt != '0 || bus.ch_req != r0) bad = 1;
        end
        chk(!bad, "chan_filter", 32'(bus.in_gnt), 0);
        bus.in_req[1] = 1'b0;

        // Round-robin from reset: 0 then 3; then 0,1,3
        apply_reset("rst1");
        push_pkt(0);
        push_pkt(3);
        request(0, 3'd0);
        request(3, 3'd0);
        wait_done(600, "rr1_done");
        push_pkt(0);
        push_pkt(1);
        push_pkt(3);
        request(0, 3'd0);
        request(1, 3'd0);
        request(3, 3'd0);
        wait_done(900, "rr2_done");

        // Slow downstream on flit 4
        slow_idx = 4;
        push_pkt(2);
        request(2, 3'd0);
        wait_fidx(5, 1'b0, "slow_reach");
        f0  = bus.ch_flit;
        r0  = bus.ch_req;
        bad = 0;
        repeat (15) begin
            tick();
            if (bus.ch_flit != f0 || bus.buf_addr != 3'd4 || bus.ch_req != r0) bad = 1;
        end
        chk(!bad, "slow_hold", 32'(bus.buf_addr), 4);
        wait_done(400, "slow_done");
        slow_idx = -1;

        // Late arrival of port 1 during port 0's packet
        push_pkt(0);
        push_pkt(1);
        request(0, 3'd0);
        wait_fidx(3, 1'b1, "late_reach");
        request(1, 3'd0);
        wait_done(600, "late_done");

        // Reset after the third ack, then a fresh packet
        push_pkt(2);
        request(2, 3'd0);
        wait_fidx(3, 1'b1, "mid_reach");
        apply_reset("rst_mid");
        push_pkt(2);
        request(2, 3'd0);
        wait_done(300, "restart_done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
